// File: rtl/branch_predictor_cp4.sv
// Purpose : direct-mapped tagged 2-bit-counter branch predictor; fetch lookup, guess pipelined to execute, training and stats.
// Latency : fetch guess is combinational; it reaches br_pred_taken 2 unstalled edges later; table write visible next cycle.
// Backpr. : stall holds the decode/execute guess registers and blocks training/stats; flush zeroes only the decode slot.
//
// Ports:
//   clk, rst_n                  core clock, synchronous active-low reset
//   bp_en                       predictor enable (0 forces not-taken guesses, freezes stats)
//   pc_fetch, pc_execute        PCs of the fetch and execute instructions
//   is_br, br_taken             execute-stage branch flag and resolved outcome
//   stall, flush                pipeline hold / fetch+decode kill
//   pred_taken_fetch            combinational guess for pc_fetch
//   br_pred_taken               guess aligned with the execute instruction
//   mispredict                  combinational execute mispredict flag (unqualified by stall)
//   br_count, mispred_count     wrapping statistics counters
module branch_predictor_cp4 #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 30 - IDX_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bp_en,
    input  logic [31:0] pc_fetch,
    input  logic [31:0] pc_execute,
    input  logic        is_br,
    input  logic        br_taken,
    input  logic        stall,
    input  logic        flush,
    output logic        pred_taken_fetch,
    output logic        br_pred_taken,
    output logic        mispredict,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [1:0]          ctr_q [ENTRIES];

    logic [IDX_BITS-1:0] idx_f;
    logic [IDX_BITS-1:0] idx_x;
    logic [TAG_BITS-1:0] tag_f;
    logic [TAG_BITS-1:0] tag_x;
    logic                hit_f;
    logic                hit_x;
    logic                update;
    logic                pred_d;

    // Instructions are word aligned; the low PC bits carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_fetch[1:0], pc_execute[1:0]};

    assign idx_f = pc_fetch[IDX_BITS+1:2];
    assign tag_f = pc_fetch[31:IDX_BITS+2];
    assign idx_x = pc_execute[IDX_BITS+1:2];
    assign tag_x = pc_execute[31:IDX_BITS+2];

    // Lookup reads the registered table, so a same-cycle write is not bypassed.
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_x = valid_q[idx_x] && (tag_q[idx_x] == tag_x);

    assign pred_taken_fetch = bp_en && hit_f && ctr_q[idx_f][1];
    assign mispredict       = is_br && bp_en && (br_taken != br_pred_taken);
    assign update           = is_br && !stall;

    // Table training runs independently of bp_en so the table stays warm.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (update) begin
            if (hit_x) begin
                if (br_taken) begin
                    if (ctr_q[idx_x] != 2'b11) ctr_q[idx_x] <= ctr_q[idx_x] + 2'd1;
                end else begin
                    if (ctr_q[idx_x] != 2'b00) ctr_q[idx_x] <= ctr_q[idx_x] - 2'd1;
                end
            end else begin
                // Miss or alias: replace the entry with a weak counter toward the outcome.
                valid_q[idx_x] <= 1'b1;
                tag_q[idx_x]   <= tag_x;
                ctr_q[idx_x]   <= br_taken ? 2'b10 : 2'b01;
            end
        end
    end

    // Flush kills the decode slot but the execute slot still advances unless stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_d        <= 1'b0;
            br_pred_taken <= 1'b0;
        end else if (flush) begin
            pred_d <= 1'b0;
            if (!stall) br_pred_taken <= pred_d;
        end else if (!stall) begin
            pred_d        <= pred_taken_fetch;
            br_pred_taken <= pred_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else if (update && bp_en) begin
            br_count <= br_count + 32'd1;
            if (mispredict) mispred_count <= mispred_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor_cp4.sv
// Purpose : self-checking bench for branch_predictor_cp4; directed scenarios plus randomized traffic vs a behavioural model.
// Latency : model mirrors the observable timing (combinational lookup, 2-stage guess pipeline).
// Backpr. : stall/flush driven both deliberately and randomly.
module tb_branch_predictor_cp4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bp_en;
    logic [31:0] pc_fetch;
    logic [31:0] pc_execute;
    logic        is_br;
    logic        br_taken;
    logic        stall;
    logic        flush;
    logic        pred_taken_fetch;
    logic        br_pred_taken;
    logic        mispredict;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor_cp4 dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bp_en           (bp_en),
        .pc_fetch        (pc_fetch),
        .pc_execute      (pc_execute),
        .is_br           (is_br),
        .br_taken        (br_taken),
        .stall           (stall),
        .flush           (flush),
        .pred_taken_fetch(pred_taken_fetch),
        .br_pred_taken   (br_pred_taken),
        .mispredict      (mispredict),
        .br_count        (br_count),
        .mispred_count   (mispred_count)
    );

    // ---------------- behavioural model ----------------
    bit          m_valid [64];
    int          m_tag   [64];
    int          m_ctr   [64];   // 0..3, 2 and above means "predict taken"
    logic        m_dec;          // guess held for the decode instruction
    logic        m_exe;          // guess held for the execute instruction
    logic [31:0] m_br;
    logic [31:0] m_mis;
    bit          m_ok = 1'b0;

    function automatic int m_index(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int m_tagof(input logic [31:0] pc);
        return int'(pc >> 8);
    endfunction

    function automatic logic m_guess(input logic [31:0] pc, input logic en);
        int i;
        i = m_index(pc);
        return en && m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic m_miss_flag();
        return is_br && bp_en && (br_taken != m_exe);
    endfunction

    always @(posedge clk) begin : model
        logic guess_now;
        logic wrong_now;
        int   xi;
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[i] = 1'b0;
                m_tag[i]   = 0;
                m_ctr[i]   = 1;
            end
            m_dec = 1'b0;
            m_exe = 1'b0;
            m_br  = 32'd0;
            m_mis = 32'd0;
            m_ok  = 1'b1;
        end else begin
            guess_now = m_guess(pc_fetch, bp_en);
            wrong_now = m_miss_flag();
            if (is_br && !stall) begin
                if (bp_en) begin
                    m_br = m_br + 32'd1;
                    if (wrong_now) m_mis = m_mis + 32'd1;
                end
                xi = m_index(pc_execute);
                if (m_valid[xi] && m_tag[xi] == m_tagof(pc_execute)) begin
                    m_ctr[xi] = br_taken ? ((m_ctr[xi] + 1 > 3) ? 3 : m_ctr[xi] + 1)
                                         : ((m_ctr[xi] - 1 < 0) ? 0 : m_ctr[xi] - 1);
                end else begin
                    m_valid[xi] = 1'b1;
                    m_tag[xi]   = m_tagof(pc_execute);
                    m_ctr[xi]   = br_taken ? 2 : 1;
                end
            end
            if (flush) begin
                if (!stall) m_exe = m_dec;
                m_dec = 1'b0;
            end else if (!stall) begin
                m_exe = m_dec;
                m_dec = guess_now;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (m_ok && rst_n) begin
            chk("pred_taken_fetch", {31'd0, pred_taken_fetch}, {31'd0, m_guess(pc_fetch, bp_en)});
            chk("br_pred_taken",    {31'd0, br_pred_taken},    {31'd0, m_exe});
            chk("mispredict",       {31'd0, mispredict},       {31'd0, m_miss_flag()});
            chk("br_count",         br_count,                  m_br);
            chk("mispred_count",    mispred_count,             m_mis);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] PC_A = 32'h1000_0040;
    localparam logic [31:0] PC_B = 32'h1000_0140;   // same index as PC_A, different tag
    localparam logic [31:0] PC_C = 32'h1000_0200;   // unrelated index

    initial begin : stim
        int pulses;
        logic [31:0] pcs [4];
        pcs[0] = PC_A; pcs[1] = PC_B; pcs[2] = PC_C; pcs[3] = 32'hFFFF_FFFC;

        rst_n = 1'b0; bp_en = 1'b1; pc_fetch = '0; pc_execute = '0;
        is_br = 1'b0; br_taken = 1'b0; stall = 1'b0; flush = 1'b0;

        // Reset
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_br_pred_taken", {31'd0, br_pred_taken}, 32'd0);
        chk("rst_br_count", br_count, 32'd0);
        chk("rst_mispred_count", mispred_count, 32'd0);
        for (int i = 0; i < 4; i++) begin
            pc_fetch = pcs[i];
            #1 chk("rst_pred_fetch", {31'd0, pred_taken_fetch}, 32'd0);
        end

        // Training on PC_A: 10, 11, 11, then 10, then 01
        pc_fetch = PC_A; pc_execute = PC_A; is_br = 1'b1; br_taken = 1'b1;
        tick();
        chk("train_1_taken", {31'd0, pred_taken_fetch}, 32'd1);
        tick(); tick();
        chk("train_3_taken", {31'd0, pred_taken_fetch}, 32'd1);
        br_taken = 1'b0;
        tick();
        chk("train_1_nt", {31'd0, pred_taken_fetch}, 32'd1);
        tick();
        chk("train_2_nt", {31'd0, pred_taken_fetch}, 32'd0);

        // Aliasing: saturate PC_A, then replace via PC_B
        br_taken = 1'b1;
        tick(); tick();
        chk("alias_pre", {31'd0, pred_taken_fetch}, 32'd1);
        pc_execute = PC_B; br_taken = 1'b0;
        tick();
        is_br = 1'b0;
        #1 chk("alias_a_miss", {31'd0, pred_taken_fetch}, 32'd0);
        pc_fetch = PC_B;
        #1 chk("alias_b_weak_nt", {31'd0, pred_taken_fetch}, 32'd0);
        is_br = 1'b1; br_taken = 1'b1;
        tick();
        is_br = 1'b0;
        #1 chk("alias_b_weak_t", {31'd0, pred_taken_fetch}, 32'd1);

        // Pipeline alignment: retrain PC_A with zeros flowing through the pipe
        pc_fetch = '0; pc_execute = PC_A; is_br = 1'b1; br_taken = 1'b1;
        tick(); tick();
        is_br = 1'b0; pc_fetch = PC_A;
        tick();
        pc_fetch = '0;
        chk("pipe_edge1", {31'd0, br_pred_taken}, 32'd0);
        tick();
        chk("pipe_edge2", {31'd0, br_pred_taken}, 32'd1);
        tick();
        chk("pipe_edge3", {31'd0, br_pred_taken}, 32'd0);

        // Stall for 3 cycles in the middle: 5 edges total
        pc_fetch = PC_A;
        tick();
        pc_fetch = '0; stall = 1'b1;
        tick(); tick(); tick();
        chk("stall_edge4", {31'd0, br_pred_taken}, 32'd0);
        stall = 1'b0;
        tick();
        chk("stall_edge5", {31'd0, br_pred_taken}, 32'd1);
        tick();

        // Flush with the decode slot holding a taken guess
        pc_fetch = PC_A;
        tick();
        flush = 1'b1;
        tick();
        chk("flush_exec_advances", {31'd0, br_pred_taken}, 32'd1);
        flush = 1'b0; pc_fetch = '0;
        tick();
        chk("flush_killed_decode", {31'd0, br_pred_taken}, 32'd0);

        // Counters: clean reset, train with bp_en=0 (no counting)
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; bp_en = 1'b0;
        pc_fetch = PC_A; pc_execute = PC_A; is_br = 1'b1; br_taken = 1'b1;
        tick(); tick();
        chk("cnt_off_br", br_count, 32'd0);
        is_br = 1'b0; bp_en = 1'b1;
        tick(); tick();
        chk("cnt_pipe_full", {31'd0, br_pred_taken}, 32'd1);
        pc_execute = PC_C; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            is_br = 1'b1;
            br_taken = !(i == 1 || i == 4 || i == 6 || i == 9);
            #1 chk("cnt_mispredict", {31'd0, mispredict}, {31'd0, !br_taken});
            if (mispredict) pulses++;
            tick();
        end
        is_br = 1'b0;
        chk("cnt_pulses", pulses, 32'd4);
        chk("cnt_br_10", br_count, 32'd10);
        chk("cnt_mis_4", mispred_count, 32'd4);
        stall = 1'b1; is_br = 1'b1; br_taken = 1'b0;
        #1 chk("stall_mispredict_raw", {31'd0, mispredict}, 32'd1);
        tick();
        is_br = 1'b0; stall = 1'b0;
        chk("stall_br_hold", br_count, 32'd10);
        chk("stall_mis_hold", mispred_count, 32'd4);

        // Enable off: no guess, no mispredict, no counting, table still trains
        bp_en = 1'b0; pc_fetch = PC_A;
        #1 chk("off_pred", {31'd0, pred_taken_fetch}, 32'd0);
        pc_execute = PC_A; is_br = 1'b1; br_taken = 1'b0;
        #1 chk("off_mispredict", {31'd0, mispredict}, 32'd0);
        tick(); tick();
        is_br = 1'b0;
        chk("off_br_hold", br_count, 32'd10);
        chk("off_mis_hold", mispred_count, 32'd4);
        bp_en = 1'b1;
        #1 chk("off_table_trained", {31'd0, pred_taken_fetch}, 32'd0);

        // Randomized traffic over a small PC pool to force hits and aliases
        for (int n = 0; n < 4000; n++) begin
            pc_fetch   = 32'h1000_0000 | ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2);
            pc_execute = 32'h1000_0000 | ($urandom_range(0, 2) << 8) | ($urandom_range(0, 7) << 2);
            is_br    = ($urandom_range(0, 99) < 50);
            br_taken = ($urandom_range(0, 99) < 60);
            stall    = ($urandom_range(0, 99) < 15);
            flush    = ($urandom_range(0, 99) < 10);
            bp_en    = ($urandom_range(0, 99) < 90);
            rst_n    = !($urandom_range(0, 999) < 5);
            tick();
        end
        rst_n = 1'b1; is_br = 1'b0; stall = 1'b0; flush = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
